acc4_sequencer: RTL and testbench

Sequential front/back end for the 4-bit adder-subtractor. Accepts one operation per handshake, drives the adder-subtractor's A/B/sel inputs from an internal 4-bit accumulator and a latched operand, and captures the returned sum and carry. It then updates the accumulator and the status flags and returns the result over a ready/valid handshake. The combinational adder-subtractor is instantiated beside this block at the same level, so this block is both its upstream and its downstream stage.

---
 rtl/acc4_pkg.sv | 19 +
 rtl/acc4_flags.sv | 38 +++
 rtl/addsub4.sv | 15 +
 rtl/acc4_sequencer.sv | 98 +++++++++
 tb/tb_acc4_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/acc4_pkg.sv
// Shared encodings and widths for the 4-bit accumulator sequencer.
package acc4_pkg;

    localparam int W = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/acc4_flags.sv
// Next accumulator and status-flag values for the op being executed.
module acc4_flags
    import acc4_pkg::*;
(
    input  op_t          op,
    input  logic [W-1:0] operand,
    input  logic [W-1:0] acc,
    input  logic [W-1:0] add_s,
    input  logic         add_co,
    output logic [W-1:0] acc_nxt,
    output logic         c_nxt,
    output logic         v_nxt,
    output logic         z_nxt,
    output logic         n_nxt
);

    logic [W-1:0] b_eff;

    // The adder result is only meaningful for ADD/SUB; LOAD/CLEAR ignore it.
    always_comb begin
        acc_nxt = '0;
        c_nxt   = 1'b0;
        v_nxt   = 1'b0;
        b_eff   = operand ^ {W{op == OP_SUB}};
        case (op)
            OP_LOAD: acc_nxt = operand;
            OP_ADD, OP_SUB: begin
                acc_nxt = add_s;
                c_nxt   = add_co;
                v_nxt   = (acc[W-1] == b_eff[W-1]) && (add_s[W-1] != acc[W-1]);
            end
            default: acc_nxt = '0;
        endcase
        z_nxt = (acc_nxt == '0);
        n_nxt = acc_nxt[W-1];
    end

endmodule

// File: rtl/addsub4.sv
// Combinational 4-bit adder-subtractor: s = a + (b ^ {4{sel}}) + sel.
module addsub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sel,
    output logic [3:0] s,
    output logic       co
);

    // Subtraction is a plus the two's complement of b; co=1 means no borrow.
    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b ^ {4{sel}}} + {4'b0000, sel};
    end

endmodule

// File: rtl/acc4_sequencer.sv
// Handshaked sequencer around an external 4-bit adder-subtractor.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a request; op/operand latched on handshake
// ST_EXEC | adder driven from registers; result captured at cycle end
// ST_RESP | result and flags presented until res_ready
module acc4_sequencer
    import acc4_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_op,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_sel,
    input  logic [W-1:0] add_s,
    input  logic         add_co,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] acc,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c,
    output logic         flag_v,
    output logic         ov_sticky
);

    state_t       state, state_nxt;
    op_t          op_q;
    logic [W-1:0] data_q;
    logic [W-1:0] acc_nxt;
    logic         c_nxt, v_nxt, z_nxt, n_nxt;

    assign in_ready  = (state == ST_IDLE);
    assign res_valid = (state == ST_RESP);
    assign add_a     = acc;
    assign add_b     = data_q;
    assign add_sel   = (op_q == OP_SUB);

    acc4_flags u_flags (
        .op      (op_q),
        .operand (data_q),
        .acc     (acc),
        .add_s   (add_s),
        .add_co  (add_co),
        .acc_nxt (acc_nxt),
        .c_nxt   (c_nxt),
        .v_nxt   (v_nxt),
        .z_nxt   (z_nxt),
        .n_nxt   (n_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: EXEC always lasts one cycle, RESP waits for the consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, and accumulator/flag update at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_LOAD;
            data_q    <= '0;
            acc       <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            ov_sticky <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            op_q   <= op_t'(in_op);
            data_q <= in_data;
        end else if (state == ST_EXEC) begin
            acc       <= acc_nxt;
            flag_z    <= z_nxt;
            flag_n    <= n_nxt;
            flag_c    <= c_nxt;
            flag_v    <= v_nxt;
            ov_sticky <= (op_q == OP_CLEAR) ? 1'b0 : (ov_sticky | v_nxt);
        end
    end

endmodule

// File: tb/tb_acc4_sequencer.sv
// Directed plus randomized checks of acc4_sequencer wired to addsub4.
module tb_acc4_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [1:0] in_op;
    logic [3:0] in_data;
    logic [3:0] add_a, add_b, add_s;
    logic       add_sel, add_co;
    logic       res_valid, res_ready;
    logic [3:0] acc;
    logic       flag_z, flag_n, flag_c, flag_v, ov_sticky;

    int nvec = 0;
    int nerr = 0;

    // Reference state
    int m_acc;
    bit m_z, m_n, m_c, m_v, m_st;

    always #5 clk = ~clk;

    acc4_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_sel(add_sel), .add_s(add_s), .add_co(add_co),
        .res_valid(res_valid), .res_ready(res_ready),
        .acc(acc), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .ov_sticky(ov_sticky)
    );

    addsub4 u_addsub (.a(add_a), .b(add_b), .sel(add_sel), .s(add_s), .co(add_co));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v > 7) ? v - 16 : v;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_st = 0;
    endtask

    // Arithmetic view of each op: unsigned for carry, signed range for overflow.
    task automatic model_op(input int op, input int d);
        int r;
        case (op)
            0: begin m_acc = d; m_c = 0; m_v = 0; end
            1: begin
                m_c   = (m_acc + d) > 15;
                r     = sx(m_acc) + sx(d);
                m_v   = (r < -8) || (r > 7);
                m_acc = (m_acc + d) % 16;
            end
            2: begin
                m_c   = (m_acc >= d);
                r     = sx(m_acc) - sx(d);
                m_v   = (r < -8) || (r > 7);
                m_acc = (m_acc + 16 - d) % 16;
            end
            default: begin m_acc = 0; m_c = 0; m_v = 0; end
        endcase
        m_z  = (m_acc == 0);
        m_n  = (m_acc >= 8);
        m_st = (op == 3) ? 1'b0 : (m_st | m_v);
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_acc"}, {4'h0, acc}, 8'(m_acc));
        chk({tag, "_z"}, {7'h0, flag_z}, {7'h0, m_z});
        chk({tag, "_n"}, {7'h0, flag_n}, {7'h0, m_n});
        chk({tag, "_c"}, {7'h0, flag_c}, {7'h0, m_c});
        chk({tag, "_v"}, {7'h0, flag_v}, {7'h0, m_v});
        chk({tag, "_sticky"}, {7'h0, ov_sticky}, {7'h0, m_st});
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge, idle again.
    task automatic do_op(input logic [1:0] op, input logic [3:0] d, input int stall);
        int pre_acc;
        pre_acc   = m_acc;
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = d;
        res_ready = (stall == 0);
        chk("idle_in_ready", {7'h0, in_ready}, 8'h01);
        @(negedge clk);
        if (stall == 0) in_valid = 1'b0;
        in_data = ~d;
        in_op   = ~op;
        model_op(int'(op), int'(d));
        chk("exec_res_valid", {7'h0, res_valid}, 8'h00);
        chk("exec_in_ready", {7'h0, in_ready}, 8'h00);
        chk("exec_add_a", {4'h0, add_a}, 8'(pre_acc));
        chk("exec_add_b", {4'h0, add_b}, {4'h0, d});
        chk("exec_add_sel", {7'h0, add_sel}, {7'h0, op == 2'b10});
        @(negedge clk);
        chk("resp_res_valid", {7'h0, res_valid}, 8'h01);
        chk_result("resp");
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_res_valid", {7'h0, res_valid}, 8'h01);
            chk("stall_in_ready", {7'h0, in_ready}, 8'h00);
            chk("stall_acc", {4'h0, acc}, 8'(m_acc));
        end
        if (stall > 0) begin
            in_valid  = 1'b0;
            res_ready = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        chk("back_in_ready", {7'h0, in_ready}, 8'h01);
        chk("back_res_valid", {7'h0, res_valid}, 8'h00);
        chk_result("back");
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_data = 4'h0; res_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_in_ready", {7'h0, in_ready}, 8'h01);
        chk("rst_res_valid", {7'h0, res_valid}, 8'h00);
        chk("rst_add_a", {4'h0, add_a}, 8'h00);
        chk("rst_add_b", {4'h0, add_b}, 8'h00);
        chk("rst_add_sel", {7'h0, add_sel}, 8'h00);
        chk_result("rst");
        @(negedge clk);
        rst_n = 1'b1;

        do_op(2'b00, 4'd5, 0);
        do_op(2'b01, 4'd3, 0);
        chk("add53_acc", {4'h0, acc}, 8'd8);
        chk("add53_v", {7'h0, flag_v}, 8'h01);
        chk("add53_c", {7'h0, flag_c}, 8'h00);
        chk("add53_sticky", {7'h0, ov_sticky}, 8'h01);

        do_op(2'b00, 4'd3, 0);
        do_op(2'b10, 4'd5, 0);
        chk("sub35_acc", {4'h0, acc}, 8'd14);
        chk("sub35_c", {7'h0, flag_c}, 8'h00);
        chk("sub35_n", {7'h0, flag_n}, 8'h01);

        do_op(2'b00, 4'd7, 0);
        do_op(2'b10, 4'd7, 0);
        chk("sub77_z", {7'h0, flag_z}, 8'h01);
        chk("sub77_c", {7'h0, flag_c}, 8'h01);

        do_op(2'b01, 4'd4, 5);

        do_op(2'b00, 4'd15, 0);
        do_op(2'b01, 4'd1, 0);
        chk("wrap_acc", {4'h0, acc}, 8'd0);
        chk("wrap_c", {7'h0, flag_c}, 8'h01);
        chk("wrap_z", {7'h0, flag_z}, 8'h01);
        chk("wrap_v", {7'h0, flag_v}, 8'h00);
        chk("pre_clear_sticky", {7'h0, ov_sticky}, 8'h01);
        do_op(2'b11, 4'd9, 0);
        chk("clear_sticky", {7'h0, ov_sticky}, 8'h00);

        // Reset in the middle of EXEC: the op is dropped.
        do_op(2'b00, 4'd6, 0);
        in_valid = 1'b1; in_op = 2'b01; in_data = 4'd9; res_ready = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        chk("midrst_in_ready", {7'h0, in_ready}, 8'h01);
        chk("midrst_res_valid", {7'h0, res_valid}, 8'h00);
        chk_result("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", {7'h0, res_valid}, 8'h00);
        end
        res_ready = 1'b0;
        do_op(2'b00, 4'd11, 0);
        do_op(2'b10, 4'd2, 1);

        for (int k = 0; k < 60; k++) begin
            do_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
